vga_image_writer: RTL and testbench



---
 rtl/vga_image_writer.sv | 208 ++++++++++++++++++++
 tb/tb_vga_image_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_image_writer.sv
// Pixel-write engine feeding vga_image: single writes with auto-increment, linear fills and
// whole-frame clear. Define VGA_IMWR_RECT_EN to replace CLEAR (op 11) with a wrapping RECT fill.
module vga_image_writer #(
  parameter int unsigned PWIDTH     = 12,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [PWIDTH-1:0]     cmd_data,
  input  logic [15:0]           cmd_len,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  image_we,
  output logic [PWIDTH-1:0]     image_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] OpSetAddr = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpFill    = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  typedef enum logic [1:0] {StIdle, StFill, StClear, StRect} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [PWIDTH-1:0]       data_q, data_d;
  logic [PWIDTH-1:0]       image_data_q, image_data_d;
  logic [16:0]             rem_q, rem_d;
  logic                    pend_q, pend_d;
  logic                    pend_last_q, pend_last_d;
  logic                    pend_multi_q, pend_multi_d;
  logic                    image_we_q, image_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef VGA_IMWR_RECT_EN
  logic [8:0]              x0_q, x0_d;
  logic [8:0]              wm1_q, wm1_d;
  logic [8:0]              colrem_q, colrem_d;
  logic [6:0]              rowrem_q, rowrem_d;
`endif

  assign cmd_ready  = (state_q == StIdle);
  assign address    = address_q;
  assign image_we   = image_we_q;
  assign image_data = image_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    address_d    = address_q;
    data_d       = data_q;
    rem_d        = rem_q;
    pend_d       = 1'b0;
    pend_last_d  = pend_last_q;
    pend_multi_d = pend_multi_q;
`ifdef VGA_IMWR_RECT_EN
    x0_d         = x0_q;
    wm1_d        = wm1_q;
    colrem_d     = colrem_q;
    rowrem_d     = rowrem_q;
`endif
    // The address issued last cycle becomes this cycle's strobe (vga_image registers address).
    image_we_d   = pend_q;
    image_data_d = pend_q ? data_q : image_data_q;
    busy_d       = pend_q & pend_multi_q;
    done_d       = pend_q & pend_last_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpSetAddr: begin
              ptr_d  = cmd_addr;
              done_d = 1'b1;
            end
            OpWrite: begin
              address_d    = ptr_q;
              ptr_d        = ptr_q + AddrOne;
              data_d       = cmd_data;
              pend_d       = 1'b1;
              pend_last_d  = 1'b1;
              pend_multi_d = 1'b0;
            end
            OpFill: begin
              ptr_d = cmd_addr + ADDR_WIDTH'(cmd_len);
              if (cmd_len == 16'd0) begin
                done_d = 1'b1;
              end else begin
                address_d    = cmd_addr;
                data_d       = cmd_data;
                pend_d       = 1'b1;
                pend_multi_d = 1'b1;
                pend_last_d  = (cmd_len == 16'd1);
                rem_d        = {1'b0, cmd_len} - 17'd1;
                state_d      = StFill;
              end
            end
            default: begin
`ifdef VGA_IMWR_RECT_EN
              ptr_d        = cmd_addr;
              address_d    = cmd_addr;
              data_d       = cmd_data;
              pend_d       = 1'b1;
              pend_multi_d = 1'b1;
              x0_d         = cmd_addr[8:0];
              wm1_d        = cmd_len[8:0];
              colrem_d     = cmd_len[8:0];
              rowrem_d     = cmd_len[15:9];
              pend_last_d  = (cmd_len == 16'd0);
              state_d      = StRect;
`else
              ptr_d        = '0;
              address_d    = '0;
              data_d       = cmd_data;
              pend_d       = 1'b1;
              pend_multi_d = 1'b1;
              pend_last_d  = 1'b0;
              rem_d        = 17'h0FFFF;
              state_d      = StClear;
`endif
            end
          endcase
        end
      end
      StFill, StClear: begin
        if (rem_q != 17'd0) begin
          address_d   = address_q + AddrOne;
          pend_d      = 1'b1;
          rem_d       = rem_q - 17'd1;
          pend_last_d = (rem_q == 17'd1);
        end else begin
          state_d = StIdle;
        end
      end
`ifdef VGA_IMWR_RECT_EN
      StRect: begin
        // Column and row fields wrap independently within their own widths.
        if (colrem_q != 9'd0) begin
          address_d   = {address_q[15:9], address_q[8:0] + 9'd1};
          colrem_d    = colrem_q - 9'd1;
          pend_d      = 1'b1;
          pend_last_d = (colrem_q == 9'd1) && (rowrem_q == 7'd0);
        end else if (rowrem_q != 7'd0) begin
          address_d   = {address_q[15:9] + 7'd1, x0_q};
          colrem_d    = wm1_q;
          rowrem_d    = rowrem_q - 7'd1;
          pend_d      = 1'b1;
          pend_last_d = (wm1_q == 9'd0) && (rowrem_q == 7'd1);
        end else begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      address_q    <= '0;
      data_q       <= '0;
      image_data_q <= '0;
      rem_q        <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_multi_q <= 1'b0;
      image_we_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef VGA_IMWR_RECT_EN
      x0_q         <= '0;
      wm1_q        <= '0;
      colrem_q     <= '0;
      rowrem_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      address_q    <= address_d;
      data_q       <= data_d;
      image_data_q <= image_data_d;
      rem_q        <= rem_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      pend_multi_q <= pend_multi_d;
      image_we_q   <= image_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef VGA_IMWR_RECT_EN
      x0_q         <= x0_d;
      wm1_q        <= wm1_d;
      colrem_q     <= colrem_d;
      rowrem_q     <= rowrem_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_image_writer.sv
// Directed bench for vga_image_writer: writes, fills, reset abort, and CLEAR or RECT.
module tb_vga_image_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [11:0] cmd_data;
  logic [15:0] cmd_len;
  logic [15:0] address;
  logic        image_we;
  logic [11:0] image_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  vga_image_writer #(.PWIDTH(12), .ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .address    (address),
    .image_we   (image_we),
    .image_data (image_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] a, input logic [11:0] d,
                     input logic [15:0] l);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = l;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] f_addr [5];
    int nbusy, nwe, nready, ndone, done_nwe, bad_addr, bad_data;
    logic done_we;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
    tick(); tick();
    chk("rst_address", address, 0);
    chk("rst_we", image_we, 0);
    chk("rst_data", image_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    tick();

    // 1: SETADDR then three back-to-back WRITEs
    cmd(2'b00, 16'h0010, 12'h000, 16'h0);
    tick();
    chk("t1_setaddr_done", done, 1);
    chk("t1_setaddr_we", image_we, 0);
    cmd(2'b01, 16'h0000, 12'hABC, 16'h0);
    tick();
    chk("t1_addr0", address, 16'h0010);
    chk("t1_we0", image_we, 0);
    chk("t1_done0", done, 0);
    tick();
    chk("t1_addr1", address, 16'h0011);
    chk("t1_we1", image_we, 1);
    chk("t1_data1", image_data, 12'hABC);
    chk("t1_done1", done, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t1_addr2", address, 16'h0012);
    chk("t1_we2", image_we, 1);
    tick();
    chk("t1_we3", image_we, 1);
    chk("t1_done3", done, 1);
    chk("t1_busy3", busy, 0);
    tick();
    chk("t1_we4", image_we, 0);
    chk("t1_done4", done, 0);

    // 2: FILL across the 0xFFFF wrap
    cmd(2'b00, 16'hFFFE, 12'h000, 16'h0);
    tick();
    cmd(2'b10, 16'hFFFE, 12'h0F0, 16'd4);
    tick();
    cmd_valid = 1'b0;
    chk("t2_addr0", address, 16'hFFFE);
    chk("t2_we0", image_we, 0);
    chk("t2_busy0", busy, 0);
    chk("t2_ready0", cmd_ready, 0);
    f_addr = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
    nbusy = 0; nwe = 0; nready = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nbusy += int'(busy);
      nwe += int'(image_we);
      if (i <= 3) begin
        nready += int'(cmd_ready);
        chk("t2_addr", address, f_addr[i-1]);
      end
      if (i == 1) chk("t2_data", image_data, 12'h0F0);
      if (i == 3) chk("t2_done_early", done, 0);
      if (i == 4) begin
        chk("t2_done_last", done, 1);
        chk("t2_we_last", image_we, 1);
      end
      if (i == 5) chk("t2_done_after", done, 0);
    end
    chk("t2_busy_cycles", nbusy, 4);
    chk("t2_we_cycles", nwe, 4);
    chk("t2_ready_low", nready, 0);

    // 3: FILL len 0 only moves the pointer
    cmd(2'b10, 16'h1234, 12'h111, 16'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_we", image_we, 0);
    chk("t3_ready", cmd_ready, 1);
    tick();
    chk("t3_done_once", done, 0);
    chk("t3_we_after", image_we, 0);
    cmd(2'b01, 16'h0000, 12'h555, 16'h0);
    tick();
    cmd_valid = 1'b0;
    chk("t3_ptr", address, 16'h1234);
    tick();
    chk("t3_wdata", image_data, 12'h555);

    // 4: WRITE held during FILL len 8 waits until after done
    cmd(2'b10, 16'h0200, 12'h321, 16'd8);
    tick();
    cmd(2'b01, 16'h0000, 12'h777, 16'h0);
    nwe = 0; nready = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      nwe += int'(image_we);
      if (i < 8) nready += int'(cmd_ready);
      if (i == 7) chk("t4_addr7", address, 16'h0207);
    end
    chk("t4_we_cycles", nwe, 8);
    chk("t4_ready_low", nready, 0);
    chk("t4_done", done, 1);
    chk("t4_ready_at_done", cmd_ready, 1);
    chk("t4_addr_hold", address, 16'h0207);
    tick();
    cmd_valid = 1'b0;
    chk("t4_write_addr", address, 16'h0208);
    chk("t4_write_we0", image_we, 0);
    tick();
    chk("t4_write_we", image_we, 1);
    chk("t4_write_data", image_data, 12'h777);
    chk("t4_write_done", done, 1);

    // 5: reset aborts a long FILL
    cmd(2'b10, 16'h3000, 12'hAAA, 16'd100);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("t5_we_pre", image_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_we", image_we, 0);
    chk("t5_addr", address, 0);
    chk("t5_data", image_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();
    chk("t5_ready", cmd_ready, 1);
    chk("t5_we_after", image_we, 0);
    tick();
    chk("t5_we_after2", image_we, 0);

`ifdef VGA_IMWR_RECT_EN
    // 6: RECT 3x2 at row 127, x 510 wrapping on both axes
    begin
      logic [15:0] r_addr [6];
      r_addr = '{16'hFFFE, 16'hFFFF, 16'hFE00, 16'h01FE, 16'h01FF, 16'h0000};
      cmd(2'b11, 16'hFFFE, 12'h0C3, 16'h0202);
      tick();
      cmd_valid = 1'b0;
      chk("t6_addr0", address, r_addr[0]);
      nwe = 0;
      for (int i = 1; i <= 5; i++) begin
        tick();
        chk("t6_addr", address, r_addr[i]);
        nwe += int'(image_we);
        if (i == 5) chk("t6_done_early", done, 0);
      end
      tick();
      chk("t6_we_last", image_we, 1);
      chk("t6_done", done, 1);
      chk("t6_we_count", nwe + int'(image_we), 6);
      tick();
      chk("t6_busy_end", busy, 0);
      cmd(2'b01, 16'h0000, 12'h001, 16'h0);
      tick();
      cmd_valid = 1'b0;
      chk("t6_ptr", address, 16'hFFFE);
    end
`else
    // 6: CLEAR writes the whole frame
    cmd(2'b11, 16'h5555, 12'h0C3, 16'h1234);
    tick();
    cmd_valid = 1'b0;
    chk("t6_addr0", address, 16'h0000);
    nwe = 0; ndone = 0; done_nwe = 0; done_we = 1'b0; bad_addr = 0; bad_data = 0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (image_we) begin
        nwe++;
        if (image_data !== 12'h0C3) bad_data++;
        if (address !== ((nwe < 65536) ? 16'(nwe) : 16'hFFFF)) bad_addr++;
      end
      if (done) begin
        ndone++;
        done_nwe = nwe;
        done_we = image_we;
      end
      if (ndone != 0 && !busy) break;
    end
    chk("t6_we_count", nwe, 65536);
    chk("t6_done_count", ndone, 1);
    chk("t6_done_at_last", done_nwe, 65536);
    chk("t6_done_with_we", done_we, 1);
    chk("t6_bad_addr", bad_addr, 0);
    chk("t6_bad_data", bad_data, 0);
    cmd(2'b01, 16'h0000, 12'h001, 16'h0);
    tick();
    cmd_valid = 1'b0;
    chk("t6_ptr", address, 16'h0000);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
